// File: rtl/tl_rr_arbiter_if.sv
// TileLink-UL link bundle. With LANES > 1 the A payload and both valid/ready
// pairs are packed per lane, while the D payload stays a single shared bus.
interface tl_rr_arbiter_if #(
   parameter int LANES     = 1,
   parameter int XLEN      = 32,
   parameter int SID_WIDTH = 2
);
   logic [LANES-1:0]            a_valid;
   logic [LANES-1:0]            a_ready;
   logic [3*LANES-1:0]          a_opcode;
   logic [3*LANES-1:0]          a_param;
   logic [3*LANES-1:0]          a_size;
   logic [SID_WIDTH*LANES-1:0]  a_source;
   logic [XLEN*LANES-1:0]       a_address;
   logic [(XLEN/8)*LANES-1:0]   a_mask;
   logic [XLEN*LANES-1:0]       a_data;

   logic [LANES-1:0]            d_valid;
   logic [LANES-1:0]            d_ready;
   logic [2:0]                  d_opcode;
   logic [1:0]                  d_param;
   logic [2:0]                  d_size;
   logic [SID_WIDTH-1:0]        d_source;
   logic [XLEN-1:0]             d_data;
   logic                        d_corrupt;
   logic                        d_denied;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
      output d_ready,
      input  a_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_data, d_corrupt, d_denied
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
      input  d_ready,
      output a_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_data, d_corrupt, d_denied
   );
endinterface

// File: rtl/tl_rr_arbiter.sv
// Round-robin TileLink-UL arbiter: one master at a time owns the slave port
// from its A request until the matching D response completes.
module tl_rr_arbiter #(
   parameter  int NUM_MASTERS = 2,
   parameter  int XLEN        = 32,
   parameter  int SID_WIDTH   = 2,
   localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic             clk,
   input  logic             reset,
   tl_rr_arbiter_if.slave   m,
   tl_rr_arbiter_if.master  s,
   output logic             busy,
   output logic [IDX_W-1:0] grant_idx
);
   localparam int MW = XLEN / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t           state_r;
   logic [IDX_W-1:0] last_r;
   logic [IDX_W-1:0] grant_r;
   logic             busy_r;
   logic [IDX_W-1:0] pick_s;
   logic             a_fire_s;
   logic             d_fire_s;
   int unsigned      gsel_s;

   // First requester strictly after 'last', wrapping, so the last winner ranks lowest.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                input logic [IDX_W-1:0]       last);
      logic [IDX_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx = (int'(last) + k) % NUM_MASTERS;
         if (!found && req[idx]) begin
            pick  = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign pick_s   = rr_pick(m.a_valid, last_r);
   assign gsel_s   = 32'(grant_r);
   assign a_fire_s = s.a_valid & s.a_ready;
   assign d_fire_s = s.d_valid & s.d_ready;

   assign busy      = busy_r;
   assign grant_idx = grant_r;

   // Arbitration FSM: grant, owner index, fairness pointer and busy flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         last_r  <= IDX_W'(NUM_MASTERS - 1);
         grant_r <= {IDX_W{1'b0}};
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|m.a_valid) begin
                  grant_r <= pick_s;
                  state_r <= ST_ADDR;
                  busy_r  <= 1'b1;
               end
            end
            ST_ADDR: begin
               if (a_fire_s) begin
                  state_r <= ST_RESP;
               end else if (!m.a_valid[grant_r]) begin
                  // Requester withdrew before acceptance: drop the grant, keep fairness pointer.
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_RESP: begin
               if (d_fire_s) begin
                  last_r  <= grant_r;
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Granted master's A payload routed to the slave; only the valid is gated by state.
   assign s.a_opcode  = m.a_opcode[gsel_s*3 +: 3];
   assign s.a_param   = m.a_param[gsel_s*3 +: 3];
   assign s.a_size    = m.a_size[gsel_s*3 +: 3];
   assign s.a_source  = m.a_source[gsel_s*SID_WIDTH +: SID_WIDTH];
   assign s.a_address = m.a_address[gsel_s*XLEN +: XLEN];
   assign s.a_mask    = m.a_mask[gsel_s*MW +: MW];
   assign s.a_data    = m.a_data[gsel_s*XLEN +: XLEN];

   assign m.d_opcode  = s.d_opcode;
   assign m.d_param   = s.d_param;
   assign m.d_size    = s.d_size;
   assign m.d_source  = s.d_source;
   assign m.d_data    = s.d_data;
   assign m.d_corrupt = s.d_corrupt;
   assign m.d_denied  = s.d_denied;

   // Handshake steering: A path open only in ADDR, D path only in RESP.
   always_comb begin
      s.a_valid = 1'b0;
      s.d_ready = 1'b0;
      m.a_ready = {NUM_MASTERS{1'b0}};
      m.d_valid = {NUM_MASTERS{1'b0}};
      case (state_r)
         ST_ADDR: begin
            s.a_valid          = m.a_valid[grant_r];
            m.a_ready[grant_r] = s.a_ready;
         end
         ST_RESP: begin
            m.d_valid[grant_r] = s.d_valid;
            s.d_ready          = m.d_ready[grant_r];
         end
         default: begin
            s.a_valid = 1'b0;
            s.d_ready = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_tl_rr_arbiter.sv
// Self-checking bench for tl_rr_arbiter: vector table, directed corner
// sequences, then random traffic against a transaction-level ownership model.
module tb_tl_rr_arbiter;
   localparam int N    = 2;
   localparam int XLEN = 32;
   localparam int SIDW = 2;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       busy;
   logic [0:0] grant_idx;

   logic        mv    [N];
   logic [2:0]  mop   [N];
   logic [31:0] maddr [N];
   logic [31:0] mdata [N];
   logic [3:0]  mmask [N];
   logic [1:0]  msrc  [N];

   int n_checks = 0;
   int n_fail   = 0;

   // ownership model: own = -1 when nobody holds the port
   int   own;
   int   lastm;
   int   gntm;
   bit   sent;
   logic       e_sav;
   logic [1:0] e_mar;
   logic [1:0] e_mdv;
   logic       e_sdr;
   logic       acc [N];
   int   nf;
   int   order [4];

   typedef struct {
      logic [1:0] av;
      logic       sar;
      logic       sdv;
      logic [1:0] mdr;
      logic       sav;
      logic [1:0] mar;
      logic [1:0] mdv;
      logic       sdr;
      logic       bsy;
      logic       gnt;
   } vec_t;
   vec_t vt [14];

   tl_rr_arbiter_if #(.LANES(N), .XLEN(XLEN), .SID_WIDTH(SIDW)) mif ();
   tl_rr_arbiter_if #(.LANES(1), .XLEN(XLEN), .SID_WIDTH(SIDW)) sif ();

   tl_rr_arbiter #(.NUM_MASTERS(N), .XLEN(XLEN), .SID_WIDTH(SIDW)) dut (
      .clk       (clk),
      .reset     (reset),
      .m         (mif),
      .s         (sif),
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         mif.a_valid[i]                = mv[i];
         mif.a_opcode[3*i +: 3]        = mop[i];
         mif.a_param[3*i +: 3]         = 3'd0;
         mif.a_size[3*i +: 3]          = 3'd2;
         mif.a_source[SIDW*i +: SIDW]  = msrc[i];
         mif.a_address[XLEN*i +: XLEN] = maddr[i];
         mif.a_data[XLEN*i +: XLEN]    = mdata[i];
         mif.a_mask[4*i +: 4]          = mmask[i];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < N; i++) begin
         mv[i] = 1'b0; mop[i] = 3'd4; maddr[i] = 32'h0; mdata[i] = 32'h0;
         mmask[i] = 4'hF; msrc[i] = 2'd0;
      end
      sif.a_ready   = 1'b0;
      sif.d_valid   = 1'b0;
      sif.d_opcode  = 3'd1;
      sif.d_param   = 2'd0;
      sif.d_size    = 3'd2;
      sif.d_source  = 2'd0;
      sif.d_data    = 32'h0;
      sif.d_corrupt = 1'b0;
      sif.d_denied  = 1'b0;
      mif.d_ready   = 2'b00;
   endtask

   // Reset with every requester and the slave active; outputs must stay quiet.
   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      mv[0] = 1'b1; mv[1] = 1'b1;
      sif.a_ready = 1'b1; sif.d_valid = 1'b1; mif.d_ready = 2'b11;
      tick();
      chk("reset busy",      64'(busy),          64'd0);
      chk("reset s_a_valid", 64'(sif.a_valid),   64'd0);
      chk("reset m_a_ready", 64'(mif.a_ready),   64'd0);
      chk("reset m_d_valid", 64'(mif.d_valid),   64'd0);
      chk("reset s_d_ready", 64'(sif.d_ready),   64'd0);
      chk("reset grant_idx", 64'(grant_idx),     64'd0);
      tick();
      reset = 1'b1;
      idle_inputs();
      own = -1; lastm = N - 1; gntm = 0; sent = 1'b0;
   endtask

   initial begin
      //          av     sar   sdv   mdr    | sav   mar    mdv    sdr   bsy   gnt
      vt[0]  = '{2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0};
      vt[2]  = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0};
      vt[3]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1};
      vt[5]  = '{2'b01, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1};
      vt[6]  = '{2'b01, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
      vt[7]  = '{2'b01, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
      vt[8]  = '{2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0};
      vt[9]  = '{2'b10, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      vt[10] = '{2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1};
      vt[11] = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1};
      vt[12] = '{2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1};
      vt[13] = '{2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};

      idle_inputs();
      do_reset();

      // Single Get from m0, response one cycle after acceptance.
      mv[0] = 1'b1; mop[0] = 3'd4; maddr[0] = 32'h100; msrc[0] = 2'd1; sif.a_ready = 1'b1;
      #2;
      chk("get idle s_a_valid", 64'(sif.a_valid), 64'd0);
      tick(); #2;
      chk("get s_a_valid",   64'(sif.a_valid),   64'd1);
      chk("get s_a_address", 64'(sif.a_address), 64'h100);
      chk("get s_a_opcode",  64'(sif.a_opcode),  64'd4);
      chk("get s_a_source",  64'(sif.a_source),  64'd1);
      chk("get m_a_ready",   64'(mif.a_ready),   64'b01);
      tick();
      mv[0] = 1'b0; sif.d_valid = 1'b1; sif.d_data = 32'hDEADBEEF; sif.d_source = 2'd1;
      mif.d_ready = 2'b11;
      #2;
      chk("get m_d_valid",  64'(mif.d_valid),  64'b01);
      chk("get m_d_data",   64'(mif.d_data),   64'hDEADBEEF);
      chk("get m_d_source", 64'(mif.d_source), 64'd1);
      chk("get s_d_ready",  64'(sif.d_ready),  64'd1);
      tick();
      sif.d_valid = 1'b0;
      #2;
      chk("get busy after", 64'(busy), 64'd0);

      // Vector table from a fresh reset.
      do_reset();
      for (int k = 0; k < 14; k++) begin
         mv[0] = vt[k].av[0]; mv[1] = vt[k].av[1];
         sif.a_ready = vt[k].sar; sif.d_valid = vt[k].sdv; mif.d_ready = vt[k].mdr;
         #2;
         chk($sformatf("vec%0d s_a_valid", k), 64'(sif.a_valid), 64'(vt[k].sav));
         chk($sformatf("vec%0d m_a_ready", k), 64'(mif.a_ready), 64'(vt[k].mar));
         chk($sformatf("vec%0d m_d_valid", k), 64'(mif.d_valid), 64'(vt[k].mdv));
         chk($sformatf("vec%0d s_d_ready", k), 64'(sif.d_ready), 64'(vt[k].sdr));
         chk($sformatf("vec%0d busy", k),      64'(busy),        64'(vt[k].bsy));
         chk($sformatf("vec%0d grant_idx", k), 64'(grant_idx),   64'(vt[k].gnt));
         tick();
      end

      // Both masters request continuously: grants must alternate 0,1,0,1.
      do_reset();
      mv[0] = 1'b1; mv[1] = 1'b1; sif.a_ready = 1'b1; sif.d_valid = 1'b1; mif.d_ready = 2'b11;
      nf = 0;
      for (int c = 0; c < 40 && nf < 4; c++) begin
         #2;
         if (mif.d_valid != 2'b00) chk("rr no accept in RESP", 64'(mif.a_ready), 64'd0);
         if (sif.a_valid && sif.a_ready) begin
            order[nf] = int'(grant_idx);
            nf++;
         end
         tick();
      end
      chk("rr fire count", 64'(nf), 64'd4);
      for (int k = 0; k < 4; k++) chk($sformatf("rr order%0d", k), 64'(order[k]), 64'(k % 2));

      // m1 PutFullData stalled by the slave for 5 cycles, then a slow D consumer.
      do_reset();
      mv[1] = 1'b1; mop[1] = 3'd0; maddr[1] = 32'h200; mdata[1] = 32'h12345678; mmask[1] = 4'hF;
      tick();
      for (int c = 0; c < 5; c++) begin
         #2;
         chk($sformatf("put stall%0d s_a_valid", c), 64'(sif.a_valid), 64'd1);
         chk($sformatf("put stall%0d m_a_ready", c), 64'(mif.a_ready), 64'd0);
         chk($sformatf("put stall%0d s_a_data", c),  64'(sif.a_data),  64'h12345678);
         chk($sformatf("put stall%0d s_a_mask", c),  64'(sif.a_mask),  64'hF);
         chk($sformatf("put stall%0d grant", c),     64'(grant_idx),   64'd1);
         tick();
      end
      sif.a_ready = 1'b1;
      #2;
      chk("put accept m_a_ready", 64'(mif.a_ready), 64'b10);
      tick();
      sif.d_valid = 1'b1; mif.d_ready = 2'b01;
      for (int c = 0; c < 3; c++) begin
         #2;
         chk($sformatf("put hold%0d s_a_valid", c), 64'(sif.a_valid), 64'd0);
         chk($sformatf("put hold%0d m_a_ready", c), 64'(mif.a_ready), 64'd0);
         chk($sformatf("put hold%0d s_d_ready", c), 64'(sif.d_ready), 64'd0);
         chk($sformatf("put hold%0d m_d_valid", c), 64'(mif.d_valid), 64'b10);
         chk($sformatf("put hold%0d busy", c),      64'(busy),        64'd1);
         tick();
      end
      mif.d_ready = 2'b10;
      #2;
      chk("put complete s_d_ready", 64'(sif.d_ready), 64'd1);
      tick();
      sif.d_valid = 1'b0; mv[1] = 1'b0;
      #2;
      chk("put busy after", 64'(busy), 64'd0);

      // Reset while in RESP, then both request: master 0 first.
      do_reset();
      mv[0] = 1'b1; sif.a_ready = 1'b1;
      tick(); tick();
      mv[0] = 1'b0; sif.d_valid = 1'b1; mif.d_ready = 2'b00;
      #2;
      chk("abort in RESP busy", 64'(busy), 64'd1);
      do_reset();
      mv[0] = 1'b1; mv[1] = 1'b1; sif.a_ready = 1'b1;
      tick(); #2;
      chk("abort regrant idx",     64'(grant_idx), 64'd0);
      chk("abort regrant m_a_rdy", 64'(mif.a_ready), 64'b01);

      // Random traffic against the ownership model.
      do_reset();
      for (int i = 0; i < N; i++) acc[i] = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (mv[i] && !acc[i]) begin
               if ($urandom_range(0, 15) == 0) mv[i] = 1'b0;
            end else begin
               mv[i]    = ($urandom_range(0, 2) != 0);
               mop[i]   = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd0;
               maddr[i] = $urandom();
               mdata[i] = $urandom();
               msrc[i]  = 2'($urandom_range(0, 3));
            end
         end
         sif.a_ready = 1'($urandom_range(0, 1));
         sif.d_valid = 1'($urandom_range(0, 1));
         sif.d_data  = $urandom();
         mif.d_ready = 2'($urandom_range(0, 3));
         #2;
         e_sav = 1'b0; e_mar = 2'b00; e_mdv = 2'b00; e_sdr = 1'b0;
         if (own >= 0) begin
            if (!sent) begin
               e_sav      = mv[own];
               e_mar[own] = sif.a_ready;
            end else begin
               e_mdv[own] = sif.d_valid;
               e_sdr      = mif.d_ready[own];
            end
         end
         chk("rnd s_a_valid", 64'(sif.a_valid), 64'(e_sav));
         chk("rnd m_a_ready", 64'(mif.a_ready), 64'(e_mar));
         chk("rnd m_d_valid", 64'(mif.d_valid), 64'(e_mdv));
         chk("rnd s_d_ready", 64'(sif.d_ready), 64'(e_sdr));
         chk("rnd busy",      64'(busy),        64'(own >= 0));
         chk("rnd grant_idx", 64'(grant_idx),   64'(gntm));
         chk("rnd m_d_data",  64'(mif.d_data),  64'(sif.d_data));
         if (e_sav) begin
            chk("rnd s_a_address", 64'(sif.a_address), 64'(maddr[own]));
            chk("rnd s_a_data",    64'(sif.a_data),    64'(mdata[own]));
            chk("rnd s_a_source",  64'(sif.a_source),  64'(msrc[own]));
         end
         for (int i = 0; i < N; i++) acc[i] = e_mar[i] && mv[i];
         tick();
         if (own < 0) begin
            if (mv[0] || mv[1]) begin
               for (int k = 1; k <= N; k++)
                  if (own < 0 && mv[(lastm + k) % N]) own = (lastm + k) % N;
               gntm = own;
               sent = 1'b0;
            end
         end else if (!sent) begin
            if (mv[own] && sif.a_ready) sent = 1'b1;
            else if (!mv[own]) own = -1;
         end else if (sif.d_valid && mif.d_ready[own]) begin
            lastm = own;
            own   = -1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
